// File: rtl/palette_pkg.sv
// Shared types, fade-state encoding and the reset-default colour table for the sprite palette.
package palette_pkg;

  localparam int unsigned DEF_CH_W    = 4;
  localparam logic [4:0]  BRIGHT_FULL = 5'd16;
  localparam logic [4:0]  BRIGHT_ZERO = 5'd0;

  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_FADE_OUT = 2'd1,
    FS_FADE_IN  = 2'd2
  } fade_state_t;

  // Entries above 4 repeat the sky-blue of entry 0, whatever the table depth.
  function automatic rgb_t default_pal(input int unsigned idx);
    rgb_t c;
    case (idx)
      1:       c = '{r: 4'h9, g: 4'h4, b: 4'h0};
      2:       c = '{r: 4'h0, g: 4'h0, b: 4'h0};
      3:       c = '{r: 4'hF, g: 4'hF, b: 4'hF};
      4:       c = '{r: 4'h5, g: 4'h2, b: 4'h0};
      default: c = '{r: 4'h6, g: 4'hA, b: 4'hF};
    endcase
    return c;
  endfunction

  // MSB-aligns a 4-bit default channel onto a channel of width w (w <= 16).
  function automatic logic [15:0] widen_ch(input logic [3:0] nib, input int unsigned w);
    logic [19:0] t;
    t = 20'(nib) << w;
    t = t >> 4;
    return t[15:0];
  endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Brightness fade engine: steps a 0..16 brightness register once every FADE_DIV fade_tick pulses.
// bright and fade_busy are registered; bright changes one cycle after the qualifying tick.
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int unsigned FADE_DIV = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       fade_tick,
  input  logic       fade_start,
  input  logic       fade_dir,
  output logic [4:0] bright,
  output logic       fade_busy
);

  localparam int unsigned     CNT_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_DIV - 1);

  fade_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bright_q, bright_d;
  logic             busy_q, busy_d;

  logic going_up;
  logic at_bound;
  logic last_step;

  assign going_up  = (state_q == FS_FADE_IN);
  assign at_bound  = going_up ? (bright_q == BRIGHT_FULL) : (bright_q == BRIGHT_ZERO);
  assign last_step = going_up ? (bright_q == BRIGHT_FULL - 5'd1) : (bright_q == BRIGHT_ZERO + 5'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bright_d = bright_q;
    case (state_q)
      FS_IDLE: begin
        cnt_d = '0;
        if (fade_start) state_d = fade_dir ? FS_FADE_IN : FS_FADE_OUT;
      end
      FS_FADE_OUT, FS_FADE_IN: begin
        if (fade_start) begin
          // Restart keeps the current brightness; only direction and the tick phase change.
          state_d = fade_dir ? FS_FADE_IN : FS_FADE_OUT;
          cnt_d   = '0;
        end else if (at_bound) begin
          state_d = FS_IDLE;
          cnt_d   = '0;
        end else if (fade_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            bright_d = going_up ? (bright_q + 5'd1) : (bright_q - 5'd1);
            if (last_step) state_d = FS_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = FS_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != FS_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= FS_IDLE;
      cnt_q    <= '0;
      bright_q <= BRIGHT_FULL;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
      busy_q   <= busy_d;
    end
  end

  assign bright    = bright_q;
  assign fade_busy = busy_q;

endmodule

// File: rtl/palette_lut_rt.sv
// Runtime-programmable sprite palette: raw index -> remap -> RGB -> brightness scale.
// Latency 2 cycles, one pixel per cycle, no backpressure (never stalls).
module palette_lut_rt
  import palette_pkg::*;
#(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned FADE_DIV   = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                pix_valid,
  input  logic [IDX_W-1:0]    pix_idx,
  input  logic                pal_we,
  input  logic [IDX_W-1:0]    pal_waddr,
  input  logic [3*CH_W-1:0]   pal_wdata,
  input  logic                map_we,
  input  logic [IDX_W-1:0]    map_waddr,
  input  logic [IDX_W-1:0]    map_wdata,
  input  logic                fade_tick,
  input  logic                fade_start,
  input  logic                fade_dir,
  output logic                out_valid,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                transp,
  output logic                fade_busy
);

  localparam int unsigned NUM_ENT = 2**IDX_W;
  localparam int unsigned RGB_W   = 3*CH_W;
  localparam int unsigned PROD_W  = CH_W + 5;

  function automatic logic [RGB_W-1:0] pal_reset(input int unsigned i);
    rgb_t        c;
    logic [15:0] r, g, b;
    c = default_pal(i);
    r = widen_ch(c.r, CH_W);
    g = widen_ch(c.g, CH_W);
    b = widen_ch(c.b, CH_W);
    return {r[CH_W-1:0], g[CH_W-1:0], b[CH_W-1:0]};
  endfunction

  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch, input logic [4:0] br);
    logic [PROD_W-1:0] p;
    p = PROD_W'(ch) * PROD_W'(br);
    return p[CH_W+3:4];
  endfunction

  logic [RGB_W-1:0] pal_q [NUM_ENT];
  logic [RGB_W-1:0] pal_d [NUM_ENT];
  logic [IDX_W-1:0] map_q [NUM_ENT];
  logic [IDX_W-1:0] map_d [NUM_ENT];

  logic [IDX_W-1:0] m_idx_q, m_idx_d;
  logic [RGB_W-1:0] rgb1_q, rgb1_d;
  logic             v1_q, v1_d;

  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  red_q, red_d;
  logic [CH_W-1:0]  green_q, green_d;
  logic [CH_W-1:0]  blue_q, blue_d;
  logic             transp_q, transp_d;

  logic [4:0]       bright;

  palette_fade_ctrl #(
    .FADE_DIV (FADE_DIV)
  ) u_fade (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .fade_tick  (fade_tick),
    .fade_start (fade_start),
    .fade_dir   (fade_dir),
    .bright     (bright),
    .fade_busy  (fade_busy)
  );

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      pal_d[i] = pal_q[i];
      map_d[i] = map_q[i];
    end
    if (pal_we) pal_d[pal_waddr] = pal_wdata;
    if (map_we) map_d[map_waddr] = map_wdata;
  end

  // Both tables are read in the pixel's issue cycle so a write in that same cycle is not seen.
  always_comb begin
    v1_d    = pix_valid;
    m_idx_d = map_q[pix_idx];
    rgb1_d  = pal_q[m_idx_d];
  end

  always_comb begin
    out_valid_d = v1_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    transp_d    = transp_q;
    if (v1_q) begin
      red_d    = scale_ch(rgb1_q[RGB_W-1 -: CH_W], bright);
      green_d  = scale_ch(rgb1_q[2*CH_W-1 -: CH_W], bright);
      blue_d   = scale_ch(rgb1_q[CH_W-1 -: CH_W], bright);
      transp_d = (m_idx_q == IDX_W'(TRANSP_IDX));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_ENT; i++) begin
        pal_q[i] <= pal_reset(i);
        map_q[i] <= IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        pal_q[i] <= pal_d[i];
        map_q[i] <= map_d[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1_q        <= 1'b0;
      m_idx_q     <= '0;
      rgb1_q      <= '0;
      out_valid_q <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      transp_q    <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      m_idx_q     <= m_idx_d;
      rgb1_q      <= rgb1_d;
      out_valid_q <= out_valid_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      transp_q    <= transp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign transp    = transp_q;

endmodule

// File: tb/tb_palette_lut_rt.sv
// Randomised scoreboard bench for palette_lut_rt against a table/arithmetic reference model.
module tb_palette_lut_rt;

  localparam int FD = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [3:0]  pix_idx = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_waddr = '0;
  logic [11:0] pal_wdata = '0;
  logic        map_we = 1'b0;
  logic [3:0]  map_waddr = '0;
  logic [3:0]  map_wdata = '0;
  logic        fade_tick = 1'b0;
  logic        fade_start = 1'b0;
  logic        fade_dir = 1'b0;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transp;
  logic        fade_busy;

  always #5 Clk = ~Clk;

  palette_lut_rt #(
    .IDX_W(4), .CH_W(4), .TRANSP_IDX(0), .FADE_DIV(FD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid), .pix_idx(pix_idx),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
    .fade_tick(fade_tick), .fade_start(fade_start), .fade_dir(fade_dir),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .transp(transp), .fade_busy(fade_busy)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          edge_n = 0;
  logic [12:0] exp_q[$];
  int          due_q[$];
  logic [11:0] pal_m[16];
  logic [3:0]  map_m[16];
  int          bright_m, mode_m, cnt_m;
  logic        busy_m;
  logic [12:0] last_out;
  logic        mon_en = 1'b0;

  always @(posedge Clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      map_m[i] = 4'(i);
      pal_m[i] = 12'h6AF;
    end
    pal_m[1] = 12'h940; pal_m[2] = 12'h000; pal_m[3] = 12'hFFF; pal_m[4] = 12'h520;
    bright_m = 16; mode_m = 0; cnt_m = 0; busy_m = 1'b0; last_out = '0;
    exp_q.delete();
    due_q.delete();
  endtask

  // One clock of stimulus; mode_m: 0 idle, 1 fading toward black, 2 fading toward full.
  task automatic cycle(input logic pv, input logic [3:0] idx,
                       input logic pwe, input logic [3:0] pa, input logic [11:0] pd,
                       input logic mwe, input logic [3:0] ma, input logic [3:0] md,
                       input logic tk, input logic st, input logic dr);
    logic [3:0]  m;
    logic [11:0] c;
    int r, g, b;
    @(negedge Clk);
    pix_valid = pv; pix_idx = idx;
    pal_we = pwe; pal_waddr = pa; pal_wdata = pd;
    map_we = mwe; map_waddr = ma; map_wdata = md;
    fade_tick = tk; fade_start = st; fade_dir = dr;
    m = map_m[idx];
    c = pal_m[m];
    if (pwe) pal_m[pa] = pd;
    if (mwe) map_m[ma] = md;
    if (st) begin
      mode_m = dr ? 2 : 1;
      cnt_m = 0;
    end else if ((mode_m == 1 && bright_m == 0) || (mode_m == 2 && bright_m == 16)) begin
      mode_m = 0;
    end else if (mode_m != 0 && tk) begin
      cnt_m++;
      if (cnt_m == FD) begin
        cnt_m = 0;
        bright_m = bright_m + ((mode_m == 2) ? 1 : -1);
        if (bright_m == 0 || bright_m == 16) mode_m = 0;
      end
    end
    if (mode_m == 0) cnt_m = 0;
    busy_m = (mode_m != 0);
    if (pv) begin
      r = c[11:8] * bright_m / 16;
      g = c[7:4] * bright_m / 16;
      b = c[3:0] * bright_m / 16;
      exp_q.push_back({(m == 4'd0), 4'(r), 4'(g), 4'(b)});
      due_q.push_back(edge_n + 2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    mon_en = 1'b0;
    pix_valid = 0; pal_we = 0; map_we = 0; fade_tick = 0; fade_start = 0; fade_dir = 0;
    #2 Reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_rgb_transp", {red, green, blue, transp}, 0);
    check("rst_fade_busy", fade_busy, 0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int due;
    forever begin
      @(posedge Clk);
      #1;
      if (mon_en && Reset_n) begin
        check("fade_busy", fade_busy, busy_m);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
          end else begin
            last_out = exp_q.pop_front();
            due = due_q.pop_front();
            check("latency", edge_n, due);
            check("pixel", {transp, red, green, blue}, last_out);
          end
        end else begin
          check("hold", {transp, red, green, blue}, last_out);
          if (due_q.size() > 0 && due_q[0] <= edge_n) begin
            check("out_valid", out_valid, 1);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required end of test first");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Default table stream, only index 0 transparent.
    for (int i = 0; i < 5; i++) cycle(1, 4'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Remap writes.
    cycle(0, 0, 0, 0, 0, 1, 4'd1, 4'd3, 0, 0, 0);
    cycle(1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 4'd3, 4'd0, 0, 0, 0);
    cycle(1, 4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Palette write in the same cycle as a read of that entry.
    cycle(1, 4'd2, 1, 4'd2, 12'hABC, 0, 0, 0, 0, 0, 0);
    cycle(1, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Full fade out then in, watching a white pixel (entry 4 remapped to 3).
    cycle(0, 0, 0, 0, 0, 1, 4'd4, 4'd3, 0, 1, 0);
    for (int i = 0; i < 40; i++) cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, i[0], 0, 0);
    cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 40; i++) cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, i[0], 0, 0);
    cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(3);

    // Reverse mid fade at brightness 8.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 60 && bright_m != 8; i++) cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 24; i++) cycle(1, 4'd4, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Reset while fading and streaming, then confirm default tables.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cycle(1, 4'(i), 1, 4'(i), 12'h123, 0, 0, 0, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 4'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), 12'($urandom()),
            $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
    end
    idle(4);
    check("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
